dmem_access_ctrl: RTL and testbench

Data-memory access sequencer between the single-cycle core's control/datapath and a handshaked word-wide data memory port. It decodes the core's `read_mem`/`write_mem` and size strobes into one or two word transactions with byte enables. It stalls the core until the access completes and returns sign- or zero-extended load data.

---
 rtl/dmem_pkg.sv | 34 +++
 rtl/dmem_access_ctrl_if.sv | 20 ++
 rtl/dmem_load_align.sv | 26 ++
 rtl/dmem_access_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_dmem_access_ctrl.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types, size masks and lane helpers for the data-memory sequencer
package dmem_pkg;

  typedef enum logic [1:0] {IDLE, ACC0, ACC1, DONE} dmem_state_e;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} dmem_size_e;

  localparam logic [3:0] MASK_B = 4'h1;
  localparam logic [3:0] MASK_H = 4'h3;
  localparam logic [3:0] MASK_W = 4'hF;

  function automatic logic [3:0] size_mask(dmem_size_e sz);
    case (sz)
      SZ_W:    return MASK_W;
      SZ_H:    return MASK_H;
      default: return MASK_B;
    endcase
  endfunction

  // [3:0] are the lanes of the first word, [7:4] the lanes spilling into the next word
  function automatic logic [7:0] be_mask(dmem_size_e sz, logic [1:0] off);
    return {4'h0, size_mask(sz)} << off;
  endfunction

  function automatic logic crosses(dmem_size_e sz, logic [1:0] off);
    return (sz == SZ_H && off == 2'd3) || (sz == SZ_W && off != 2'd0);
  endfunction

  function automatic logic [31:0] rotl_bytes(logic [31:0] w, logic [1:0] off);
    logic [63:0] dbl;
    dbl = {w, w} << {off, 3'b000};
    return dbl[63:32];
  endfunction

endpackage

// File: rtl/dmem_access_ctrl_if.sv
// rtl/dmem_access_ctrl_if.sv - handshaked word-wide data memory port
interface dmem_access_ctrl_if #(parameter int WIDTH = 32);
  logic             bus_req;
  logic             bus_we;
  logic [WIDTH-1:0] bus_addr;
  logic [3:0]       bus_be;
  logic [WIDTH-1:0] bus_wdata;
  logic             bus_ready;
  logic [WIDTH-1:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    input  bus_ready, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    output bus_ready, bus_rdata
  );
endinterface

// File: rtl/dmem_load_align.sv
// rtl/dmem_load_align.sv - merges captured words, rotates to lane 0, masks and extends load data
module dmem_load_align
  import dmem_pkg::*;
(
  input  logic [31:0] lo_word,
  input  logic [31:0] hi_word,
  input  logic [1:0]  offset,
  input  dmem_size_e  size,
  input  logic        zero_ext,
  output logic [31:0] data
);

  logic [63:0] both;
  logic [31:0] shifted;

  always_comb begin
    both    = {hi_word, lo_word} >> {offset, 3'b000};
    shifted = both[31:0];
    case (size)
      SZ_B:    data = {{24{~zero_ext & shifted[7]}}, shifted[7:0]};
      SZ_H:    data = {{16{~zero_ext & shifted[15]}}, shifted[15:0]};
      default: data = shifted;
    endcase
  end

endmodule

// File: rtl/dmem_access_ctrl.sv
// rtl/dmem_access_ctrl.sv - load/store sequencer between core control and the data memory port
// DMEM_SPLIT_EN: split word-crossing accesses into two bus beats instead of flagging misalign_err
module dmem_access_ctrl
  import dmem_pkg::*;
#(
  parameter int WIDTH = 32
)
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             read_mem,
  input  logic             write_mem,
  input  logic             one_byte,
  input  logic             two_bytes,
  input  logic             four_byte,
  input  logic             load_unsigned,
  input  logic [WIDTH-1:0] addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] load_data,
  output logic             stall,
  output logic             misalign_err,
  dmem_access_ctrl_if.master bus
);

  dmem_state_e      state_q, state_d;
  dmem_size_e       size_q, req_size;
  logic [1:0]       off_q, req_off;
  logic             uns_q, req_valid, req_cross;
  logic             req_q, we_q;
  logic [3:0]       be_q;
  logic [WIDTH-1:0] baddr_q, wd_q, w0_q, load_q, align_lo, align_out;
`ifdef DMEM_SPLIT_EN
  logic             cross_q;
  logic [3:0]       hi_be;
`else
  logic             err_q;
`endif

  assign req_valid = read_mem | write_mem;
  // one_byte is implied: with no wider strobe set the access is a byte
  assign req_size  = four_byte ? SZ_W : (two_bytes ? SZ_H : SZ_B);
  assign req_off   = addr[1:0];
  assign req_cross = crosses(req_size, req_off);

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
`ifdef DMEM_SPLIT_EN
          state_d = ACC0;
`else
          state_d = req_cross ? DONE : ACC0;
`endif
        end
      end
      ACC0: begin
        if (bus.bus_ready) begin
`ifdef DMEM_SPLIT_EN
          state_d = cross_q ? ACC1 : DONE;
`else
          state_d = DONE;
`endif
        end
      end
`ifdef DMEM_SPLIT_EN
      ACC1: if (bus.bus_ready) state_d = DONE;
`endif
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign stall = (state_q == IDLE && req_valid) || state_q == ACC0 || state_q == ACC1;

  // First word comes straight off the bus when it is also the last beat
  assign align_lo = (state_q == ACC0) ? bus.bus_rdata : w0_q;

  dmem_load_align u_align (
    .lo_word  (align_lo),
    .hi_word  (bus.bus_rdata),
    .offset   (off_q),
    .size     (size_q),
    .zero_ext (uns_q),
    .data     (align_out)
  );

`ifdef DMEM_SPLIT_EN
  assign hi_be = 4'(be_mask(size_q, off_q) >> 4);
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      size_q  <= SZ_B;
      off_q   <= 2'd0;
      uns_q   <= 1'b0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      be_q    <= 4'h0;
      baddr_q <= '0;
      wd_q    <= '0;
      w0_q    <= '0;
      load_q  <= '0;
`ifdef DMEM_SPLIT_EN
      cross_q <= 1'b0;
`else
      err_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            size_q  <= req_size;
            off_q   <= req_off;
            uns_q   <= load_unsigned;
            we_q    <= write_mem;
            baddr_q <= {addr[WIDTH-1:2], 2'b00};
            be_q    <= 4'(be_mask(req_size, req_off));
            wd_q    <= rotl_bytes(wdata, req_off);
`ifdef DMEM_SPLIT_EN
            cross_q <= req_cross;
            req_q   <= 1'b1;
`else
            if (req_cross) begin
              err_q  <= 1'b1;
              load_q <= '0;
            end else begin
              req_q  <= 1'b1;
            end
`endif
          end
        end
        ACC0: begin
          if (bus.bus_ready) begin
            w0_q <= bus.bus_rdata;
`ifdef DMEM_SPLIT_EN
            if (cross_q) begin
              baddr_q <= baddr_q + WIDTH'(4);
              be_q    <= hi_be;
            end else begin
              req_q <= 1'b0;
              if (!we_q) load_q <= align_out;
            end
`else
            req_q <= 1'b0;
            if (!we_q) load_q <= align_out;
`endif
          end
        end
`ifdef DMEM_SPLIT_EN
        ACC1: begin
          if (bus.bus_ready) begin
            req_q <= 1'b0;
            if (!we_q) load_q <= align_out;
          end
        end
`endif
        DONE: begin
`ifndef DMEM_SPLIT_EN
          err_q <= 1'b0;
`endif
        end
        default: ;
      endcase
    end
  end

  assign load_data     = load_q;
  assign bus.bus_req   = req_q;
  assign bus.bus_we    = we_q;
  assign bus.bus_addr  = baddr_q;
  assign bus.bus_be    = be_q;
  assign bus.bus_wdata = wd_q;
`ifdef DMEM_SPLIT_EN
  assign misalign_err  = 1'b0;
`else
  assign misalign_err  = err_q;
`endif

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// tb/tb_dmem_access_ctrl.sv - directed vector bench for dmem_access_ctrl
// Expectations for word-crossing vectors follow DMEM_SPLIT_EN
module tb_dmem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        read_mem = 1'b0, write_mem = 1'b0;
  logic        one_byte = 1'b0, two_bytes = 1'b0, four_byte = 1'b0;
  logic        load_unsigned = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic [31:0] load_data;
  logic        stall, misalign_err;

  int checks = 0;
  int errors = 0;

  dmem_access_ctrl_if #(.WIDTH(32)) bus_if ();

  dmem_access_ctrl #(.WIDTH(32)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .read_mem      (read_mem),
    .write_mem     (write_mem),
    .one_byte      (one_byte),
    .two_bytes     (two_bytes),
    .four_byte     (four_byte),
    .load_unsigned (load_unsigned),
    .addr          (addr),
    .wdata         (wdata),
    .load_data     (load_data),
    .stall         (stall),
    .misalign_err  (misalign_err),
    .bus           (bus_if.master)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        rm, wm;
    logic [2:0]  sz;        // {four_byte, two_bytes, one_byte}
    logic        uns;
    logic [31:0] a, wd, rd0, rd1;
    int          waits;
    int          beats;
    logic [31:0] exp_a0;
    logic [3:0]  exp_be0, exp_be1;
    logic [31:0] exp_wd;
    logic        chk_load;
    logic [31:0] exp_load;
    int          exp_stall;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string n, logic rm, logic wm, logic [2:0] sz, logic uns,
                              logic [31:0] a, logic [31:0] wd, logic [31:0] rd0, logic [31:0] rd1,
                              int waits, int beats, logic [31:0] ea0, logic [3:0] ebe0,
                              logic [3:0] ebe1, logic [31:0] ewd, logic cl, logic [31:0] el,
                              int es, logic ee);
    vec_t v;
    v.name = n; v.rm = rm; v.wm = wm; v.sz = sz; v.uns = uns;
    v.a = a; v.wd = wd; v.rd0 = rd0; v.rd1 = rd1; v.waits = waits; v.beats = beats;
    v.exp_a0 = ea0; v.exp_be0 = ebe0; v.exp_be1 = ebe1; v.exp_wd = ewd;
    v.chk_load = cl; v.exp_load = el; v.exp_stall = es; v.exp_err = ee;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Entered just after a falling edge; plays the memory side until DONE is seen
  task automatic run_vec(input vec_t v);
    int          stall_cnt, beats, wcnt;
    logic        done;
    logic [31:0] a_seen[2];
    logic [3:0]  be_seen[2];
    logic [31:0] wd_seen;
    logic        we_seen;
    stall_cnt = 0; beats = 0; wcnt = 0; done = 1'b0;
    a_seen[0] = '0; a_seen[1] = '0; be_seen[0] = '0; be_seen[1] = '0;
    wd_seen = '0; we_seen = 1'b0;
    read_mem = v.rm; write_mem = v.wm;
    {four_byte, two_bytes, one_byte} = v.sz;
    load_unsigned = v.uns; addr = v.a; wdata = v.wd;
    bus_if.bus_ready = 1'b0;
    for (int g = 0; g < 40; g++) begin
      #1;
      if (!stall) begin
        done = 1'b1;
        break;
      end
      stall_cnt++;
      if (bus_if.bus_req) begin
        if (wcnt < v.waits) begin
          bus_if.bus_ready = 1'b0;
          wcnt++;
        end else begin
          bus_if.bus_ready = 1'b1;
          bus_if.bus_rdata = (beats == 0) ? v.rd0 : v.rd1;
          if (beats < 2) begin
            a_seen[beats]  = bus_if.bus_addr;
            be_seen[beats] = bus_if.bus_be;
          end
          if (beats == 0) begin
            wd_seen = bus_if.bus_wdata;
            we_seen = bus_if.bus_we;
          end
          beats++;
          wcnt = 0;
        end
      end else begin
        bus_if.bus_ready = 1'b0;
      end
      @(negedge clk);
    end
    bus_if.bus_ready = 1'b0;
    chk({v.name, " done"}, 32'(done), 32'd1);
    chk({v.name, " stall_cycles"}, 32'(stall_cnt), 32'(v.exp_stall));
    chk({v.name, " beats"}, 32'(beats), 32'(v.beats));
    chk({v.name, " misalign_err"}, 32'(misalign_err), 32'(v.exp_err));
    chk({v.name, " done_bus_req"}, 32'(bus_if.bus_req), 32'd0);
    if (v.beats >= 1) begin
      chk({v.name, " addr0"}, a_seen[0], v.exp_a0);
      chk({v.name, " be0"}, 32'(be_seen[0]), 32'(v.exp_be0));
      chk({v.name, " we"}, 32'(we_seen), 32'(v.wm));
      if (v.wm) chk({v.name, " wdata"}, wd_seen, v.exp_wd);
    end
    if (v.beats == 2) begin
      chk({v.name, " addr1"}, a_seen[1], v.exp_a0 + 32'd4);
      chk({v.name, " be1"}, 32'(be_seen[1]), 32'(v.exp_be1));
    end
    if (v.chk_load) chk({v.name, " load_data"}, load_data, v.exp_load);
    read_mem = 1'b0; write_mem = 1'b0;
    @(negedge clk);
    #1;
    chk({v.name, " idle_stall"}, 32'(stall), 32'd0);
    chk({v.name, " idle_err"}, 32'(misalign_err), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    bus_if.bus_ready = 1'b0;
    bus_if.bus_rdata = '0;

    vecs.push_back(mk("sw_aligned", 0, 1, 3'b100, 0, 32'h104, 32'hDEADBEEF, 0, 0, 0, 1, 32'h104, 4'hF, 4'h0, 32'hDEADBEEF, 0, 0, 2, 0));
    vecs.push_back(mk("lb_sext", 1, 0, 3'b001, 0, 32'h203, 0, 32'h80FFFFFF, 0, 0, 1, 32'h200, 4'h8, 4'h0, 0, 1, 32'hFFFFFF80, 2, 0));
    vecs.push_back(mk("lbu_zext", 1, 0, 3'b001, 1, 32'h203, 0, 32'h80FFFFFF, 0, 0, 1, 32'h200, 4'h8, 4'h0, 0, 1, 32'h00000080, 2, 0));
    vecs.push_back(mk("sh_wait2", 0, 1, 3'b010, 0, 32'h302, 32'h0000A55A, 0, 0, 2, 1, 32'h300, 4'hC, 4'h0, 32'hA55A0000, 0, 0, 4, 0));
    vecs.push_back(mk("lh_sext", 1, 0, 3'b010, 0, 32'h106, 0, 32'h80011234, 0, 0, 1, 32'h104, 4'hC, 4'h0, 0, 1, 32'hFFFF8001, 2, 0));
    vecs.push_back(mk("lhu_off1", 1, 0, 3'b010, 1, 32'h101, 0, 32'h00FEDC00, 0, 0, 1, 32'h100, 4'h6, 4'h0, 0, 1, 32'h0000FEDC, 2, 0));
    vecs.push_back(mk("sb_off3", 0, 1, 3'b001, 0, 32'h003, 32'h000000AB, 0, 0, 0, 1, 32'h000, 4'h8, 4'h0, 32'hAB000000, 0, 0, 2, 0));
    vecs.push_back(mk("lw_wait1", 1, 0, 3'b100, 0, 32'h010, 0, 32'h12345678, 0, 1, 1, 32'h010, 4'hF, 4'h0, 0, 1, 32'h12345678, 3, 0));
    vecs.push_back(mk("no_size_byte", 1, 0, 3'b000, 0, 32'h001, 0, 32'h00007F00, 0, 0, 1, 32'h000, 4'h2, 4'h0, 0, 1, 32'h0000007F, 2, 0));
    vecs.push_back(mk("rd_wr_write_wins", 1, 1, 3'b100, 0, 32'h020, 32'hCAFEF00D, 0, 0, 0, 1, 32'h020, 4'hF, 4'h0, 32'hCAFEF00D, 0, 0, 2, 0));
    vecs.push_back(mk("size_priority", 1, 0, 3'b101, 0, 32'h030, 0, 32'h11223344, 0, 0, 1, 32'h030, 4'hF, 4'h0, 0, 1, 32'h11223344, 2, 0));
`ifdef DMEM_SPLIT_EN
    vecs.push_back(mk("lw_cross", 1, 0, 3'b100, 0, 32'h401, 0, 32'h44332211, 32'h88776655, 0, 2, 32'h400, 4'hE, 4'h1, 0, 1, 32'h55443322, 3, 0));
    vecs.push_back(mk("lh_cross", 1, 0, 3'b010, 0, 32'h103, 0, 32'hAA000000, 32'h000000BB, 0, 2, 32'h100, 4'h8, 4'h1, 0, 1, 32'hFFFFBBAA, 3, 0));
    vecs.push_back(mk("sw_cross", 0, 1, 3'b100, 0, 32'h206, 32'h11223344, 0, 0, 0, 2, 32'h204, 4'hC, 4'h3, 32'h33441122, 0, 0, 3, 0));
`else
    vecs.push_back(mk("lw_cross", 1, 0, 3'b100, 0, 32'h401, 0, 32'h44332211, 32'h88776655, 0, 0, 0, 0, 0, 0, 1, 32'h0, 1, 1));
    vecs.push_back(mk("lh_cross", 1, 0, 3'b010, 0, 32'h103, 0, 32'hAA000000, 32'h000000BB, 0, 0, 0, 0, 0, 0, 1, 32'h0, 1, 1));
    vecs.push_back(mk("sw_cross", 0, 1, 3'b100, 0, 32'h206, 32'h11223344, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
`endif

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_bus_req", 32'(bus_if.bus_req), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_err", 32'(misalign_err), 32'd0);
    chk("rst_load_data", load_data, 32'd0);
    chk("rst_bus_be", 32'(bus_if.bus_be), 32'd0);
    chk("rst_bus_addr", bus_if.bus_addr, 32'd0);
    chk("rst_bus_wdata", bus_if.bus_wdata, 32'd0);
    chk("rst_bus_we", 32'(bus_if.bus_we), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i]);

    // A misaligned load after a valid one must clear load_data when not split
    run_vec(vecs[7]);
    run_vec(vecs[11]);

    // Reset while ACC0 waits on the memory
    read_mem = 1'b1; four_byte = 1'b1; two_bytes = 1'b0; one_byte = 1'b0;
    addr = 32'h040; bus_if.bus_ready = 1'b0;
    @(negedge clk);
    #1;
    chk("mid_acc0_req", 32'(bus_if.bus_req), 32'd1);
    chk("mid_acc0_stall", 32'(stall), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    chk("mid_rst_req", 32'(bus_if.bus_req), 32'd0);
    chk("mid_rst_stall_req", 32'(stall), 32'd1);
    read_mem = 1'b0;
    #1;
    chk("mid_rst_stall_idle", 32'(stall), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    run_vec(mk("lw_after_rst", 1, 0, 3'b100, 0, 32'h040, 0, 32'h0BADF00D, 0, 0, 1, 32'h040, 4'hF, 4'h0, 0, 1, 32'h0BADF00D, 2, 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
